// File: rtl/vend_dispense_sched.sv
// vend_dispense_sched
// Shares one dispenser mechanism (soda motor plus dime hopper) between two
// vending front-ends. It arbitrates round-robin, acknowledges the winner, runs
// the motor pulse and the dime pay-out pulses, then signals completion.
//
// Optional build macro: VEND_COUNT_EN adds the vend_count / dime_count outputs.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   req[1:0]      vend request per front-end (level)
//   chg0/chg1     change code per front-end: 00 none, 01 one dime, 10 two dimes, 11 none
//   hopper_empty  dime hopper empty sensor (level)
//   ack[1:0]      one-cycle grant pulse to the winning front-end
//   done[1:0]     one-cycle completion pulse to the served front-end
//   soda_motor    soda actuator drive
//   dime_pulse    dime ejector drive
//   busy          high in every state except IDLE
//   hopper_wait   high while stalled for a hopper refill
//   state_dbg     current FSM state encoding
//   vend_count    (VEND_COUNT_EN) completed vends, wraps at 16 bits
//   dime_count    (VEND_COUNT_EN) dimes paid out, wraps at 16 bits
//
// Handshake: a front-end raises req[i] and holds it until it sees ack[i].
// The change code is captured only on the IDLE->GRANT edge. A req seen while
// busy is not queued; it is arbitrated on the next IDLE cycle if still high.
module vend_dispense_sched #(
  parameter int SODA_CYC = 8,
  parameter int DIME_ON  = 4,
  parameter int DIME_GAP = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] chg0,
  input  logic [1:0] chg1,
  input  logic       hopper_empty,
  output logic [1:0] ack,
  output logic [1:0] done,
  output logic       soda_motor,
  output logic       dime_pulse,
  output logic       busy,
  output logic       hopper_wait,
  output logic [2:0] state_dbg
`ifdef VEND_COUNT_EN
  ,
  output logic [15:0] vend_count,
  output logic [15:0] dime_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_SODA   = 3'd2,
    S_HWAIT  = 3'd3,
    S_DIME_H = 3'd4,
    S_DIME_L = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           state, state_d;
  logic             id, id_d;
  logic             last, last_d;   // front-end served most recently
  logic [1:0]       dimes, dimes_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sel;
  logic             cnt_exp;

  function automatic logic [1:0] dimes_of(input logic [1:0] chg);
    case (chg)
      2'b01:   dimes_of = 2'd1;
      2'b10:   dimes_of = 2'd2;
      default: dimes_of = 2'd0;
    endcase
  endfunction

  // The counter is loaded with the phase length on entry, so the phase ends
  // in the cycle where it reads 1.
  assign cnt_exp = (cnt <= CNT_W'(1));
  // On a tie the front-end not served last wins; reset leaves last=1 so
  // front-end 0 is favoured first.
  assign sel = (req == 2'b11) ? ~last : req[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      id    <= 1'b0;
      last  <= 1'b1;
      dimes <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      id    <= id_d;
      last  <= last_d;
      dimes <= dimes_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    id_d    = id;
    last_d  = last;
    dimes_d = dimes;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          id_d    = sel;
          dimes_d = sel ? dimes_of(chg1) : dimes_of(chg0);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = CNT_W'(SODA_CYC);
        state_d = S_SODA;
      end
      S_SODA, S_DIME_L: begin
        if (cnt_exp) begin
          if (dimes == 2'd0) begin
            state_d = S_DONE;
          end else if (hopper_empty) begin
            state_d = S_HWAIT;
          end else begin
            cnt_d   = CNT_W'(DIME_ON);
            state_d = S_DIME_H;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_HWAIT: begin
        if (!hopper_empty) begin
          cnt_d   = CNT_W'(DIME_ON);
          state_d = S_DIME_H;
        end
      end
      S_DIME_H: begin
        if (cnt_exp) begin
          dimes_d = dimes - 2'd1;
          cnt_d   = CNT_W'(DIME_GAP);
          state_d = S_DIME_L;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        last_d  = id;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; unreachable encodings decode to all zeros.
  always_comb begin
    ack         = 2'b00;
    done        = 2'b00;
    soda_motor  = 1'b0;
    dime_pulse  = 1'b0;
    busy        = 1'b0;
    hopper_wait = 1'b0;
    case (state)
      S_GRANT:  begin ack = id ? 2'b10 : 2'b01;  busy = 1'b1; end
      S_SODA:   begin soda_motor = 1'b1;         busy = 1'b1; end
      S_HWAIT:  begin hopper_wait = 1'b1;        busy = 1'b1; end
      S_DIME_H: begin dime_pulse = 1'b1;         busy = 1'b1; end
      S_DIME_L: begin                            busy = 1'b1; end
      S_DONE:   begin done = id ? 2'b10 : 2'b01; busy = 1'b1; end
      default:  begin end
    endcase
  end

  assign state_dbg = state;

`ifdef VEND_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_count <= 16'd0;
      dime_count <= 16'd0;
    end else begin
      if (state == S_DONE) vend_count <= vend_count + 16'd1;
      if (state == S_DIME_H && cnt_exp) dime_count <= dime_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispense_sched.sv
module tb_vend_dispense_sched;

  localparam int W = 36;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] chg0;
  logic [1:0] chg1;
  logic       hopper_empty;
  logic [1:0] ack;
  logic [1:0] done;
  logic       soda_motor;
  logic       dime_pulse;
  logic       busy;
  logic       hopper_wait;
  logic [2:0] state_dbg;
`ifdef VEND_COUNT_EN
  logic [15:0] vend_count;
  logic [15:0] dime_count;
`endif

  vend_dispense_sched dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .chg0         (chg0),
    .chg1         (chg1),
    .hopper_empty (hopper_empty),
    .ack          (ack),
    .done         (done),
    .soda_motor   (soda_motor),
    .dime_pulse   (dime_pulse),
    .busy         (busy),
    .hopper_wait  (hopper_wait),
    .state_dbg    (state_dbg)
`ifdef VEND_COUNT_EN
    ,
    .vend_count   (vend_count),
    .dime_count   (dime_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry: {ack[1:0], done[1:0], motor_cycles, dime_high_cycles, hwait_cycles, busy_cycles}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_vend(input logic [1:0] id_oh, input int mot, input int dh,
                             input int hw, input int bz);
    logic [7:0] m8, d8, h8, b8;
    m8 = mot[7:0]; d8 = dh[7:0]; h8 = hw[7:0]; b8 = bz[7:0];
    exp_q.push_back({id_oh, id_oh, m8, d8, h8, b8});
  endtask

  // ---------------- monitor ----------------
  logic       in_vend = 1'b0;
  logic [1:0] m_ack;
  int         m_mot, m_dh, m_hw, m_bz;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      in_vend = 1'b0;
    end else begin
      if (ack != 2'b00) begin
        in_vend = 1'b1;
        m_ack = ack;
        m_mot = 0; m_dh = 0; m_hw = 0; m_bz = 1;
      end else if (in_vend) begin
        m_bz++;
        m_mot += int'(soda_motor);
        m_dh  += int'(dime_pulse);
        m_hw  += int'(hopper_wait);
      end
      if (done != 2'b00) begin
        if (!in_vend) begin
          check("done_without_ack", int'(done), 0);
        end else if (exp_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_id",       int'(m_ack), int'(e[35:34]));
          check("done_id",      int'(done),  int'(e[33:32]));
          check("motor_cycles", m_mot,       int'(e[31:24]));
          check("dime_cycles",  m_dh,        int'(e[23:16]));
          check("hwait_cycles", m_hw,        int'(e[15:8]));
          check("busy_cycles",  m_bz,        int'(e[7:0]));
        end
        in_vend = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Raise a request, hold it until ack, then drop it.
  task automatic issue(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1);
    bit got;
    got = 0;
    @(negedge clk);
    req = r; chg0 = c0; chg1 = c1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin got = 1; break; end
    end
    if (!got) check("ack_timeout", 0, 1);
    req = 2'b00;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin got = 1; break; end
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit got;
    reset = 1'b0; req = 2'b00; chg0 = 2'b00; chg1 = 2'b00; hopper_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack",   int'(ack), 0);
    check("rst_done",  int'(done), 0);
    check("rst_motor", int'(soda_motor), 0);
    check("rst_dime",  int'(dime_pulse), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_hwait", int'(hopper_wait), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: front-end 0, no change: GRANT + 8 motor + DONE
    expect_vend(2'b01, 8, 0, 0, 10);
    issue(2'b01, 2'b00, 2'b00);
    wait_done();

    // 2: front-end 1, two dimes: 2 + 8 + 2*(4+4)
    expect_vend(2'b10, 8, 8, 0, 26);
    issue(2'b10, 2'b00, 2'b10);
    wait_done();

    // 3: both requesting from reset, held: 0, 1, 0
    do_reset();
    expect_vend(2'b01, 8, 0, 0, 10);
    expect_vend(2'b10, 8, 0, 0, 10);
    expect_vend(2'b01, 8, 0, 0, 10);
    @(negedge clk);
    req = 2'b11; chg0 = 2'b00; chg1 = 2'b00;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack != 2'b00) n++;
      if (n == 3) break;
    end
    check("alt_acks_seen", n, 3);
    req = 2'b00;
    wait_done();

    // 4: hopper empty at motor expiry, held 20 cycles then refilled
    hopper_empty = 1'b1;
    expect_vend(2'b01, 8, 4, 20, 38);
    issue(2'b01, 2'b01, 2'b00);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (hopper_wait) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) check("hwait_timeout", 0, 1);
    repeat (19) @(negedge clk);
    hopper_empty = 1'b0;
    wait_done();

    // 5: reset during third dime-high cycle aborts the vend
    issue(2'b10, 2'b00, 2'b10);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dime_pulse) n++;
      if (n == 3) break;
    end
    check("abort_dime_seen", n, 3);
    #2 reset = 1'b0;
    #1;
    check("abort_motor", int'(soda_motor), 0);
    check("abort_dime",  int'(dime_pulse), 0);
    check("abort_busy",  int'(busy), 0);
    check("abort_done",  int'(done), 0);
    check("abort_state", int'(state_dbg), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    // last served before abort was 0; reset must restore the favour-0 pointer
    expect_vend(2'b01, 8, 0, 0, 10);
    issue(2'b11, 2'b00, 2'b00);
    wait_done();

    // 6: three vends with change 00, 01, 10
    do_reset();
    expect_vend(2'b01, 8, 0, 0, 10);
    issue(2'b01, 2'b00, 2'b00);
    wait_done();
    expect_vend(2'b10, 8, 4, 0, 18);
    issue(2'b10, 2'b00, 2'b01);
    wait_done();
    expect_vend(2'b01, 8, 8, 0, 26);
    issue(2'b01, 2'b10, 2'b00);
    wait_done();
    repeat (2) @(negedge clk);
`ifdef VEND_COUNT_EN
    check("vend_count", int'(vend_count), 3);
    check("dime_count", int'(dime_count), 3);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
